// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit: PC holder and req/ack instruction fetcher for the MIPS core
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             instr_valid,
  input  logic             consume,
  input  logic             branch_taken,
  input  logic             jump,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      branch_off;
  logic [31:0]      branch_tgt;
  logic [31:0]      jump_tgt;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign branch_tgt = pc_plus4 + branch_off;
  assign jump_tgt   = {pc_plus4[31:28], instr_q[25:0], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (consume) begin
          // jump outranks branch, which outranks fall-through
          if (jump)              pc_d = jump_tgt;
          else if (branch_taken) pc_d = branch_tgt;
          else                   pc_d = pc_plus4;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = (state_q == REQ);
  assign instr_valid = (state_q == VALID);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign fetch_count = cnt_q;

endmodule
`default_nettype wire
